// File: rtl/multi_dataflow_tile_loop_pkg.sv
// Shared types and constants for the multi_dataflow tile-loop offset generator.
// Holds the default stream/width constants, the FSM state encoding and the
// control/flag bundles that the surrounding multi_dataflow blocks exchange.
package multi_dataflow_package;

  localparam int TILE_LOOP_NB_STREAMS = 4;
  localparam int TILE_LOOP_OFFS_W     = 32;
  localparam int TILE_LOOP_CNT_W      = 16;

  typedef enum logic [1:0] {
    TILE_IDLE   = 2'd0,
    TILE_UPDATE = 2'd1,
    TILE_VALID  = 2'd2,
    TILE_DONE   = 2'd3
  } state_tile_loop_t;

  typedef struct packed {
    logic                                            enable;
    logic                                            clear;
    logic [TILE_LOOP_CNT_W-1:0]                      inner_iters;
    logic [TILE_LOOP_CNT_W-1:0]                      outer_iters;
    logic [TILE_LOOP_NB_STREAMS*TILE_LOOP_OFFS_W-1:0] inner_stride;
    logic [TILE_LOOP_NB_STREAMS*TILE_LOOP_OFFS_W-1:0] outer_stride;
  } ctrl_tile_loop_t;

  typedef struct packed {
    logic [TILE_LOOP_NB_STREAMS*TILE_LOOP_OFFS_W-1:0] offs;
    logic                                            valid;
    logic                                            done;
    logic [TILE_LOOP_CNT_W-1:0]                      idx_inner;
    logic [TILE_LOOP_CNT_W-1:0]                      idx_outer;
  } flags_tile_loop_t;

endpackage

// File: rtl/multi_dataflow_tile_loop_offs_acc.sv
// Per-stream offset accumulator for the tile loop. Keeps the current offset and
// the base of the current outer iteration; an outer step rebases the offset on
// the advanced outer base. All sums wrap silently modulo 2^OFFS_W.
module multi_dataflow_offs_acc
  import multi_dataflow_package::*;
#(
  parameter int OFFS_W = TILE_LOOP_OFFS_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_zero_i,
  input  logic              inner_step_i,
  input  logic              outer_step_i,
  input  logic [OFFS_W-1:0] inner_stride_i,
  input  logic [OFFS_W-1:0] outer_stride_i,
  output logic [OFFS_W-1:0] offs_o
);

  logic [OFFS_W-1:0] offs_q;
  logic [OFFS_W-1:0] outer_base_q;
  logic [OFFS_W-1:0] outer_base_next;

  assign outer_base_next = outer_base_q + outer_stride_i;

  // Offset and outer-base registers; outer step takes precedence over inner step
  always_ff @(posedge clk_i) begin
    if (rst_i || load_zero_i) begin
      offs_q       <= '0;
      outer_base_q <= '0;
    end else if (outer_step_i) begin
      outer_base_q <= outer_base_next;
      offs_q       <= outer_base_next;
    end else if (inner_step_i) begin
      offs_q <= offs_q + inner_stride_i;
    end
  end

  assign offs_o = offs_q;

endmodule

// File: rtl/multi_dataflow_tile_loop.sv
// Tile-loop offset generator feeding the multi_dataflow control FSM.
// Walks an outer x inner loop, one iteration per enable request, and holds
// offsets stable while valid_o is high. Loop counts and strides are shadowed
// at start so input changes mid-run have no effect.
// Optional feature: define MULTI_DATAFLOW_TILE_LOOP_PERF_EN to get a
// saturating count of issued iterations on iter_cnt_o (tied to 0 otherwise).
module multi_dataflow_tile_loop
  import multi_dataflow_package::*;
#(
  parameter int NB_STREAMS = TILE_LOOP_NB_STREAMS,
  parameter int OFFS_W     = TILE_LOOP_OFFS_W,
  parameter int CNT_W      = TILE_LOOP_CNT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         enable_i,
  input  logic [CNT_W-1:0]             inner_iters_i,
  input  logic [CNT_W-1:0]             outer_iters_i,
  input  logic [NB_STREAMS*OFFS_W-1:0] inner_stride_i,
  input  logic [NB_STREAMS*OFFS_W-1:0] outer_stride_i,
  output logic [NB_STREAMS*OFFS_W-1:0] offs_o,
  output logic                         valid_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             idx_inner_o,
  output logic [CNT_W-1:0]             idx_outer_o,
  output logic [31:0]                  iter_cnt_o
);

  localparam logic [1:0] ST_IDLE   = TILE_IDLE;
  localparam logic [1:0] ST_UPDATE = TILE_UPDATE;
  localparam logic [1:0] ST_VALID  = TILE_VALID;
  localparam logic [1:0] ST_DONE   = TILE_DONE;

  logic [1:0]                  state_q;
  logic                        first_q;
  logic                        valid_q;
  logic                        done_q;
  logic [CNT_W-1:0]            inner_iters_q;
  logic [CNT_W-1:0]            outer_iters_q;
  logic [NB_STREAMS*OFFS_W-1:0] inner_stride_q;
  logic [NB_STREAMS*OFFS_W-1:0] outer_stride_q;
  logic [CNT_W-1:0]            idx_inner_q;
  logic [CNT_W-1:0]            idx_outer_q;

  logic             clr;
  logic [CNT_W-1:0] inner_last;
  logic [CNT_W-1:0] outer_last;
  logic             inner_more;
  logic             at_last;
  logic             zero_count;
  logic             enter_update;
  logic             acc_load_zero;
  logic             acc_inner_step;
  logic             acc_outer_step;

  assign clr        = rst_i | clear_i;
  assign inner_last = inner_iters_q - 1'b1;
  assign outer_last = outer_iters_q - 1'b1;
  assign inner_more = idx_inner_q < inner_last;
  assign at_last    = (idx_inner_q == inner_last) && (idx_outer_q == outer_last);
  assign zero_count = (inner_iters_i == '0) || (outer_iters_i == '0);

  // Requests that start a new iteration, shared by FSM and perf counter
  always_comb begin
    enter_update = 1'b0;
    if (enable_i) begin
      if (state_q == ST_IDLE)
        enter_update = !zero_count;
      else if (state_q == ST_VALID)
        enter_update = !at_last;
    end
  end

  assign acc_load_zero  = (state_q == ST_UPDATE) && first_q;
  assign acc_inner_step = (state_q == ST_UPDATE) && !first_q && inner_more;
  assign acc_outer_step = (state_q == ST_UPDATE) && !first_q && !inner_more;

  // Loop FSM with shadowed configuration, indices and registered flags
  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q        <= ST_IDLE;
      first_q        <= 1'b0;
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
      inner_iters_q  <= '0;
      outer_iters_q  <= '0;
      inner_stride_q <= '0;
      outer_stride_q <= '0;
      idx_inner_q    <= '0;
      idx_outer_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            inner_iters_q  <= inner_iters_i;
            outer_iters_q  <= outer_iters_i;
            inner_stride_q <= inner_stride_i;
            outer_stride_q <= outer_stride_i;
            if (zero_count) begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_UPDATE;
              first_q <= 1'b1;
            end
          end
        end
        ST_UPDATE: begin
          first_q <= 1'b0;
          valid_q <= 1'b1;
          state_q <= ST_VALID;
          if (first_q) begin
            idx_inner_q <= '0;
            idx_outer_q <= '0;
          end else if (inner_more) begin
            idx_inner_q <= idx_inner_q + 1'b1;
          end else begin
            idx_inner_q <= '0;
            idx_outer_q <= idx_outer_q + 1'b1;
          end
        end
        ST_VALID: begin
          if (enable_i) begin
            if (at_last) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_UPDATE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_DONE;
        end
      endcase
    end
  end

  for (genvar s = 0; s < NB_STREAMS; s++) begin : g_stream
    multi_dataflow_offs_acc #(
      .OFFS_W(OFFS_W)
    ) u_offs_acc (
      .clk_i          (clk_i),
      .rst_i          (clr),
      .load_zero_i    (acc_load_zero),
      .inner_step_i   (acc_inner_step),
      .outer_step_i   (acc_outer_step),
      .inner_stride_i (inner_stride_q[s*OFFS_W +: OFFS_W]),
      .outer_stride_i (outer_stride_q[s*OFFS_W +: OFFS_W]),
      .offs_o         (offs_o[s*OFFS_W +: OFFS_W])
    );
  end

`ifdef MULTI_DATAFLOW_TILE_LOOP_PERF_EN
  logic [31:0] iter_cnt_q;

  // Saturating count of iterations started
  always_ff @(posedge clk_i) begin
    if (clr)
      iter_cnt_q <= '0;
    else if (enter_update && (iter_cnt_q != '1))
      iter_cnt_q <= iter_cnt_q + 1'b1;
  end

  assign iter_cnt_o = iter_cnt_q;
`else
  assign iter_cnt_o = '0;
`endif

  assign valid_o     = valid_q;
  assign done_o      = done_q;
  assign idx_inner_o = idx_inner_q;
  assign idx_outer_o = idx_outer_q;

endmodule

// File: tb/tb_multi_dataflow_tile_loop.sv
// Self-checking bench for multi_dataflow_tile_loop. A loop-level model computes
// expected offsets as outer_idx*outer_stride + inner_idx*inner_stride from the
// linear iteration number, and a compare process checks every cycle; directed
// sequences add literal expectations. Honours MULTI_DATAFLOW_TILE_LOOP_PERF_EN.
module tb_multi_dataflow_tile_loop;

  localparam int NS = 4;
  localparam int OW = 32;
  localparam int CW = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             clear_i = 1'b0;
  logic             enable_i = 1'b0;
  logic [CW-1:0]    inner_iters_i = '0;
  logic [CW-1:0]    outer_iters_i = '0;
  logic [NS*OW-1:0] inner_stride_i = '0;
  logic [NS*OW-1:0] outer_stride_i = '0;
  logic [NS*OW-1:0] offs_o;
  logic             valid_o;
  logic             done_o;
  logic [CW-1:0]    idx_inner_o;
  logic [CW-1:0]    idx_outer_o;
  logic [31:0]      iter_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  multi_dataflow_tile_loop #(
    .NB_STREAMS(NS),
    .OFFS_W    (OW),
    .CNT_W     (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .enable_i       (enable_i),
    .inner_iters_i  (inner_iters_i),
    .outer_iters_i  (outer_iters_i),
    .inner_stride_i (inner_stride_i),
    .outer_stride_i (outer_stride_i),
    .offs_o         (offs_o),
    .valid_o        (valid_o),
    .done_o         (done_o),
    .idx_inner_o    (idx_inner_o),
    .idx_outer_o    (idx_outer_o),
    .iter_cnt_o     (iter_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Loop-level model: started/pending/valid/done plus linear iteration number
  logic          m_started = 1'b0;
  logic          m_zero = 1'b0;
  logic          m_pending = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_done = 1'b0;
  int            m_k = 0;
  int            m_inner = 0;
  int            m_outer = 0;
  logic [31:0]   m_cnt = '0;
  logic [NS*OW-1:0] m_is = '0;
  logic [NS*OW-1:0] m_os = '0;

  always @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      m_started <= 1'b0;
      m_zero    <= 1'b0;
      m_pending <= 1'b0;
      m_valid   <= 1'b0;
      m_done    <= 1'b0;
      m_k       <= 0;
      m_cnt     <= '0;
    end else if (!m_started) begin
      if (enable_i) begin
        m_started <= 1'b1;
        m_inner   <= int'(inner_iters_i);
        m_outer   <= int'(outer_iters_i);
        m_is      <= inner_stride_i;
        m_os      <= outer_stride_i;
        m_k       <= 0;
        if (inner_iters_i == 0 || outer_iters_i == 0) begin
          m_zero  <= 1'b1;
          m_valid <= 1'b1;
          m_done  <= 1'b1;
        end else begin
          m_pending <= 1'b1;
          m_cnt     <= m_cnt + 1;
        end
      end
    end else if (m_done) begin
      m_done <= 1'b1;
    end else if (m_pending) begin
      m_pending <= 1'b0;
      m_valid   <= 1'b1;
    end else if (enable_i) begin
      if (m_k == m_inner * m_outer - 1) begin
        m_done <= 1'b1;
      end else begin
        m_k       <= m_k + 1;
        m_pending <= 1'b1;
        m_valid   <= 1'b0;
        m_cnt     <= m_cnt + 1;
      end
    end
  end

  function automatic logic [31:0] expOffs(int s);
    logic [31:0] i_idx, o_idx, is, os;
    if (!m_started || m_zero) return 32'd0;
    i_idx = 32'(m_k % m_inner);
    o_idx = 32'(m_k / m_inner);
    is = m_is[s*OW +: OW];
    os = m_os[s*OW +: OW];
    return o_idx * os + i_idx * is;
  endfunction

  function automatic logic [31:0] expIdx(logic outer);
    if (!m_started || m_zero) return 32'd0;
    return outer ? 32'(m_k / m_inner) : 32'(m_k % m_inner);
  endfunction

  function automatic logic [31:0] expCnt();
`ifdef MULTI_DATAFLOW_TILE_LOOP_PERF_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled 1 time unit after the edge
  always @(posedge clk_i) begin
    #1;
    checkOutput("valid", 64'(valid_o), 64'(m_valid));
    checkOutput("done", 64'(done_o), 64'(m_done));
    checkOutput("iter_cnt", 64'(iter_cnt_o), 64'(expCnt()));
    if (m_valid || !m_started) begin
      for (int s = 0; s < NS; s++)
        checkOutput($sformatf("offs[%0d]", s), 64'(offs_o[s*OW +: OW]), 64'(expOffs(s)));
      checkOutput("idx_inner", 64'(idx_inner_o), 64'(expIdx(1'b0)));
      checkOutput("idx_outer", 64'(idx_outer_o), 64'(expIdx(1'b1)));
    end
  end

  task automatic applyStimulus(input logic en, input logic clr, input int idle_cycles);
    @(negedge clk_i);
    enable_i = en;
    clear_i  = clr;
    @(negedge clk_i);
    enable_i = 1'b0;
    clear_i  = 1'b0;
    repeat (idle_cycles) @(negedge clk_i);
  endtask

  task automatic setConfig(input int inner, input int outer,
                           input logic [31:0] is0, input logic [31:0] is1,
                           input logic [31:0] is2, input logic [31:0] is3,
                           input logic [31:0] os0, input logic [31:0] os1,
                           input logic [31:0] os2, input logic [31:0] os3);
    inner_iters_i  = CW'(inner);
    outer_iters_i  = CW'(outer);
    inner_stride_i = {is3, is2, is1, is0};
    outer_stride_i = {os3, os2, os1, os0};
  endtask

  initial begin
    logic [31:0] exp_s0 [6];
    logic [31:0] exp_wrap [4];
    exp_s0   = '{32'd0, 32'd4, 32'd8, 32'd100, 32'd104, 32'd108};
    exp_wrap = '{32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_FFD0};

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("reset_valid", 64'(valid_o), 64'd0);
    checkOutput("reset_offs", 64'(offs_o == '0), 64'd1);

    // 2x3 run
    setConfig(3, 2, 4, 8, 16, 4, 100, 200, 300, 100);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("run_offs0_k0", 64'(offs_o[31:0]), 64'(exp_s0[0]));
    for (int k = 1; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput($sformatf("run_offs0_k%0d", k), 64'(offs_o[31:0]), 64'(exp_s0[k]));
      checkOutput($sformatf("run_valid_k%0d", k), 64'(valid_o), 64'd1);
    end
    checkOutput("run_offs2_last", 64'(offs_o[95:64]), 64'd332);
    checkOutput("run_done_pre", 64'(done_o), 64'd0);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("run_done", 64'(done_o), 64'd1);
    checkOutput("run_done_valid", 64'(valid_o), 64'd1);
    checkOutput("run_done_offs0", 64'(offs_o[31:0]), 64'd108);
`ifdef MULTI_DATAFLOW_TILE_LOOP_PERF_EN
    checkOutput("run_iter_cnt", 64'(iter_cnt_o), 64'd6);
`else
    checkOutput("run_iter_cnt", 64'(iter_cnt_o), 64'd0);
`endif
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("done_sticky", 64'(done_o), 64'd1);

    // Zero trip count
    applyStimulus(1'b0, 1'b1, 0);
    setConfig(0, 5, 4, 8, 16, 4, 100, 200, 300, 100);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("zero_done", 64'(done_o), 64'd1);
    checkOutput("zero_valid", 64'(valid_o), 64'd1);
    checkOutput("zero_offs", 64'(offs_o == '0), 64'd1);

    // Wrap-around
    applyStimulus(1'b0, 1'b1, 0);
    setConfig(4, 1, 32'hFFFF_FFF0, 1, 2, 3, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("wrap_k0", 64'(offs_o[31:0]), 64'(exp_wrap[0]));
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput($sformatf("wrap_k%0d", k), 64'(offs_o[31:0]), 64'(exp_wrap[k]));
    end

    // Mid-run clear during UPDATE of the third iteration
    applyStimulus(1'b0, 1'b1, 0);
    setConfig(3, 2, 4, 8, 16, 4, 100, 200, 300, 100);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1);
    @(negedge clk_i);
    enable_i = 1'b1;
    @(negedge clk_i);
    enable_i = 1'b0;
    checkOutput("mid_in_update", 64'(valid_o), 64'd0);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    checkOutput("mid_clear_offs", 64'(offs_o == '0), 64'd1);
    checkOutput("mid_clear_valid", 64'(valid_o), 64'd0);
    checkOutput("mid_clear_idx", 64'({idx_inner_o, idx_outer_o}), 64'd0);
    checkOutput("mid_clear_cnt", 64'(iter_cnt_o), 64'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("restart_valid", 64'(valid_o), 64'd1);
    checkOutput("restart_offs", 64'(offs_o == '0), 64'd1);

    // Clear priority over enable in VALID
    applyStimulus(1'b1, 1'b1, 0);
    checkOutput("clr_prio_valid", 64'(valid_o), 64'd0);
    checkOutput("clr_prio_done", 64'(done_o), 64'd0);

    // Config shadowing
    applyStimulus(1'b1, 1'b0, 1);
    inner_stride_i[31:0] = 32'd50;
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("shadow_offs0", 64'(offs_o[31:0]), 64'd4);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("shadow_offs0_2", 64'(offs_o[31:0]), 64'd8);

    // Inner count of one: every advance is an outer step
    applyStimulus(1'b0, 1'b1, 0);
    setConfig(1, 3, 7, 7, 7, 7, 10, 20, 30, 40);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("inner1_offs3", 64'(offs_o[127:96]), 64'd40);
    checkOutput("inner1_outer_idx", 64'(idx_outer_o), 64'd1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("inner1_offs1", 64'(offs_o[63:32]), 64'd40);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("inner1_done", 64'(done_o), 64'd1);

    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
